regfile_writeback: RTL and testbench

Writer-side front end for the CPU's 32x32 register file write port (`rd`, `regdata`, `wer`). Merges single-cycle ALU results with out-of-order-timed load returns and presents at most one registered write per cycle. Tracks the destination registers of outstanding loads in an in-order tag queue and exports a pending-register scoreboard, which the decode stage uses to stall hazards.

---
 rtl/regfile_writeback.sv | 148 ++++++++++++++
 tb/tb_regfile_writeback.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_writeback.sv
// ============================================================================
//  Module   : regfile_writeback
//  Purpose  : Register-file write-port front end. Merges ALU results with
//             in-order load returns, tracks outstanding load destinations.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_writeback #(
    parameter int DEPTH = 4,
    parameter int XLEN  = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            alu_valid,
    input  logic [4:0]      alu_rd,
    input  logic [XLEN-1:0] alu_data,
    input  logic            ld_issue,
    input  logic [4:0]      ld_rd,
    output logic            ld_issue_ready,
    input  logic            ld_resp_valid,
    input  logic [XLEN-1:0] ld_resp_data,
    output logic            ld_resp_ready,
    output logic [4:0]      rd,
    output logic [XLEN-1:0] regdata,
    output logic            wer,
    output logic [31:0]     pending,
    output logic            err
);

    localparam int c_PW = $clog2(DEPTH);
    localparam int c_CW = c_PW + 1;
    localparam logic [c_CW-1:0] c_FULL = c_CW'(DEPTH);

    logic [4:0]      r_tag [DEPTH];
    logic [c_PW-1:0] r_wptr;
    logic [c_PW-1:0] r_rptr;
    logic [c_CW-1:0] r_count;

    logic            r_hold_valid;
    logic [4:0]      r_hold_rd;
    logic [XLEN-1:0] r_hold_data;

    logic [4:0]      r_rd;
    logic [XLEN-1:0] r_regdata;
    logic            r_wer;
    logic            r_err;

    logic            w_empty;
    logic            w_push;
    logic            w_resp_acc;
    logic            w_pop;
    logic [4:0]      w_head;
    logic [31:0]     w_pend;

    assign w_empty        = (r_count == '0);
    assign ld_issue_ready = (r_count != c_FULL);
    assign ld_resp_ready  = !r_hold_valid;
    assign w_push         = ld_issue && ld_issue_ready;
    assign w_resp_acc     = ld_resp_valid && ld_resp_ready;
    assign w_pop          = w_resp_acc && !w_empty;
    assign w_head         = r_tag[r_rptr];

    // Tag storage carries no reset; validity is defined by rptr/count.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_tag[r_wptr] <= ld_rd;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr       <= '0;
            r_rptr       <= '0;
            r_count      <= '0;
            r_hold_valid <= 1'b0;
            r_hold_rd    <= '0;
            r_hold_data  <= '0;
            r_rd         <= '0;
            r_regdata    <= '0;
            r_wer        <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + c_PW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + c_PW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CW'(1);
                2'b01:   r_count <= r_count - c_CW'(1);
                default: r_count <= r_count;
            endcase

            if ((ld_issue && !ld_issue_ready) || (w_resp_acc && w_empty)) begin
                r_err <= 1'b1;
            end

            // Fixed priority: ALU, then hold, then a fresh load response.
            if (alu_valid) begin
                r_rd      <= alu_rd;
                r_regdata <= alu_data;
                r_wer     <= (alu_rd != 5'd0);
                if (w_pop) begin
                    r_hold_valid <= 1'b1;
                    r_hold_rd    <= w_head;
                    r_hold_data  <= ld_resp_data;
                end
            end else if (r_hold_valid) begin
                r_rd         <= r_hold_rd;
                r_regdata    <= r_hold_data;
                r_wer        <= (r_hold_rd != 5'd0);
                r_hold_valid <= 1'b0;
            end else if (w_pop) begin
                r_rd      <= w_head;
                r_regdata <= ld_resp_data;
                r_wer     <= (w_head != 5'd0);
            end else begin
                r_wer <= 1'b0;
            end
        end
    end

    always_comb begin
        logic [c_PW-1:0] off;
        w_pend = '0;
        for (int i = 0; i < DEPTH; i++) begin
            off = c_PW'(i) - r_rptr;
            if ({1'b0, off} < r_count) begin
                w_pend = w_pend | (32'd1 << r_tag[i]);
            end
        end
        if (r_hold_valid) begin
            w_pend = w_pend | (32'd1 << r_hold_rd);
        end
        w_pend[0] = 1'b0;
    end

    assign pending = w_pend;
    assign rd      = r_rd;
    assign regdata = r_regdata;
    assign wer     = r_wer;
    assign err     = r_err;

endmodule

`default_nettype wire

// File: tb/tb_regfile_writeback.sv
// ============================================================================
//  Module   : tb_regfile_writeback
//  Purpose  : Directed self-checking bench for regfile_writeback.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_regfile_writeback;

    logic        clk;
    logic        rst_n;
    logic        alu_valid;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        ld_issue;
    logic [4:0]  ld_rd;
    logic        ld_issue_ready;
    logic        ld_resp_valid;
    logic [31:0] ld_resp_data;
    logic        ld_resp_ready;
    logic [4:0]  rd;
    logic [31:0] regdata;
    logic        wer;
    logic [31:0] pending;
    logic        err;

    int n_cmp = 0;
    int n_err = 0;

    regfile_writeback #(.DEPTH(4), .XLEN(32)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .alu_valid     (alu_valid),
        .alu_rd        (alu_rd),
        .alu_data      (alu_data),
        .ld_issue      (ld_issue),
        .ld_rd         (ld_rd),
        .ld_issue_ready(ld_issue_ready),
        .ld_resp_valid (ld_resp_valid),
        .ld_resp_data  (ld_resp_data),
        .ld_resp_ready (ld_resp_ready),
        .rd            (rd),
        .regdata       (regdata),
        .wer           (wer),
        .pending       (pending),
        .err           (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge; outputs are sampled and inputs driven here.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        alu_valid     = 1'b0;
        alu_rd        = '0;
        alu_data      = '0;
        ld_issue      = 1'b0;
        ld_rd         = '0;
        ld_resp_valid = 1'b0;
        ld_resp_data  = '0;
    endtask

    task automatic check_write(input string tag, input logic [4:0] e_rd, input logic [31:0] e_data);
        check_eq({tag, ".wer"}, 64'(wer), 64'd1);
        check_eq({tag, ".rd"}, 64'(rd), 64'(e_rd));
        check_eq({tag, ".data"}, 64'(regdata), 64'(e_data));
    endtask

    task automatic issue(input logic [4:0] r);
        ld_issue = 1'b1;
        ld_rd    = r;
        step();
        ld_issue = 1'b0;
    endtask

    initial begin
        idle_inputs();
        rst_n = 1'b0;
        step();
        step();
        check_eq("rst.wer", 64'(wer), 64'd0);
        check_eq("rst.rd", 64'(rd), 64'd0);
        check_eq("rst.regdata", 64'(regdata), 64'd0);
        check_eq("rst.pending", 64'(pending), 64'd0);
        check_eq("rst.err", 64'(err), 64'd0);
        check_eq("rst.issue_rdy", 64'(ld_issue_ready), 64'd1);
        check_eq("rst.resp_rdy", 64'(ld_resp_ready), 64'd1);
        rst_n = 1'b1;
        step();

        // ALU write, one-cycle pulse
        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
        step();
        idle_inputs();
        check_write("alu", 5'd5, 32'hDEADBEEF);
        step();
        check_eq("alu.wer_drop", 64'(wer), 64'd0);

        // Single load, direct write
        issue(5'd7);
        check_eq("ld.pend_set", 64'(pending), 64'h80);
        step();
        check_eq("ld.pend_hold", 64'(pending), 64'h80);
        check_eq("ld.resp_rdy", 64'(ld_resp_ready), 64'd1);
        ld_resp_valid = 1'b1; ld_resp_data = 32'h1234;
        step();
        idle_inputs();
        check_write("ld", 5'd7, 32'h1234);
        check_eq("ld.pend_clr", 64'(pending), 64'd0);
        step();
        check_eq("ld.wer_drop", 64'(wer), 64'd0);

        // Load collides with ALU, held across two ALU cycles
        issue(5'd3);
        alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 32'h55;
        ld_resp_valid = 1'b1; ld_resp_data = 32'hAA;
        step();
        idle_inputs();
        check_write("coll.alu9", 5'd9, 32'h55);
        check_eq("coll.resp_rdy0", 64'(ld_resp_ready), 64'd0);
        check_eq("coll.pend_hold", 64'(pending), 64'h8);
        alu_valid = 1'b1; alu_rd = 5'd10; alu_data = 32'h66;
        step();
        idle_inputs();
        check_write("coll.alu10", 5'd10, 32'h66);
        check_eq("coll.resp_rdy0b", 64'(ld_resp_ready), 64'd0);
        step();
        check_write("coll.held", 5'd3, 32'hAA);
        check_eq("coll.pend_clr", 64'(pending), 64'd0);
        check_eq("coll.resp_rdy1", 64'(ld_resp_ready), 64'd1);
        step();
        check_eq("coll.wer_drop", 64'(wer), 64'd0);
        check_eq("coll.err", 64'(err), 64'd0);

        // Fill the queue, overflow, drain in order
        issue(5'd1);
        issue(5'd2);
        issue(5'd2);
        issue(5'd4);
        check_eq("full.issue_rdy", 64'(ld_issue_ready), 64'd0);
        check_eq("full.pend", 64'(pending), 64'h16);
        check_eq("full.err0", 64'(err), 64'd0);
        issue(5'd6);
        check_eq("ovf.err", 64'(err), 64'd1);
        check_eq("ovf.pend", 64'(pending), 64'h16);
        ld_resp_valid = 1'b1; ld_resp_data = 32'h101;
        step();
        check_write("drain1", 5'd1, 32'h101);
        check_eq("drain1.pend", 64'(pending), 64'h14);
        check_eq("drain1.issue_rdy", 64'(ld_issue_ready), 64'd1);
        ld_resp_data = 32'h102;
        step();
        check_write("drain2", 5'd2, 32'h102);
        check_eq("drain2.pend", 64'(pending), 64'h14);
        ld_resp_data = 32'h103;
        step();
        check_write("drain3", 5'd2, 32'h103);
        check_eq("drain3.pend", 64'(pending), 64'h10);
        ld_resp_data = 32'h104;
        step();
        idle_inputs();
        check_write("drain4", 5'd4, 32'h104);
        check_eq("drain4.pend", 64'(pending), 64'd0);

        // Reset clears sticky error
        rst_n = 1'b0;
        step();
        check_eq("rst2.err", 64'(err), 64'd0);
        rst_n = 1'b1;
        step();

        // Response with empty queue
        ld_resp_valid = 1'b1; ld_resp_data = 32'h77;
        step();
        idle_inputs();
        check_eq("empty.wer", 64'(wer), 64'd0);
        check_eq("empty.err", 64'(err), 64'd1);

        // ALU write to x0: wer suppressed, data still registered
        alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'h99;
        step();
        idle_inputs();
        check_eq("x0alu.wer", 64'(wer), 64'd0);
        check_eq("x0alu.regdata", 64'(regdata), 64'h99);

        // Load to x0 still uses a tag but never shows in pending
        issue(5'd0);
        check_eq("x0ld.pend", 64'(pending), 64'd0);
        check_eq("x0ld.issue_rdy", 64'(ld_issue_ready), 64'd1);
        ld_resp_valid = 1'b1; ld_resp_data = 32'h88;
        step();
        idle_inputs();
        check_eq("x0ld.wer", 64'(wer), 64'd0);
        check_eq("x0ld.regdata", 64'(regdata), 64'h88);

        // Asynchronous reset with held entry and two queued tags
        issue(5'd11);
        issue(5'd12);
        issue(5'd13);
        alu_valid = 1'b1; alu_rd = 5'd14; alu_data = 32'h1414;
        ld_resp_valid = 1'b1; ld_resp_data = 32'hBB;
        step();
        idle_inputs();
        check_write("pre_rst.alu", 5'd14, 32'h1414);
        check_eq("pre_rst.resp_rdy", 64'(ld_resp_ready), 64'd0);
        check_eq("pre_rst.pend", 64'(pending), 64'h3800);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("arst.pend", 64'(pending), 64'd0);
        check_eq("arst.wer", 64'(wer), 64'd0);
        check_eq("arst.resp_rdy", 64'(ld_resp_ready), 64'd1);
        check_eq("arst.issue_rdy", 64'(ld_issue_ready), 64'd1);
        step();
        rst_n = 1'b1;
        step();
        alu_valid = 1'b1; alu_rd = 5'd15; alu_data = 32'hCAFE;
        step();
        idle_inputs();
        check_write("post_rst", 5'd15, 32'hCAFE);
        step();
        check_eq("post_rst.wer_drop", 64'(wer), 64'd0);
        check_eq("post_rst.pend", 64'(pending), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
